// File: rtl/farmer_pkg.sv
// Shared encodings for the farmer/fox/goat/beans crossing sequencer:
// move selects, FSM states, reject causes, bank-bit positions and move helpers.
package farmer_pkg;

  localparam logic [1:0] MV_ALONE = 2'b00;
  localparam logic [1:0] MV_FOX   = 2'b01;
  localparam logic [1:0] MV_GOAT  = 2'b10;
  localparam logic [1:0] MV_BEANS = 2'b11;

  localparam logic [1:0] REJ_NONE   = 2'b00;
  localparam logic [1:0] REJ_BANK   = 2'b01;
  localparam logic [1:0] REJ_UNSAFE = 2'b10;
  localparam logic [1:0] REJ_UNDO   = 2'b11;

  localparam int unsigned POS_F = 3;
  localparam int unsigned POS_X = 2;
  localparam int unsigned POS_G = 1;
  localparam int unsigned POS_B = 0;

  typedef enum logic [2:0] {StIdle, StPlay, StCheck, StWon, StLost} state_e;

  // Farmer always crosses; the selected passenger crosses with him.
  function automatic logic [3:0] candidate(input logic [3:0] pos, input logic [1:0] sel);
    logic [3:0] c;
    c = pos;
    c[POS_F] = ~pos[POS_F];
    unique case (sel)
      MV_FOX:   c[POS_X] = ~pos[POS_X];
      MV_GOAT:  c[POS_G] = ~pos[POS_G];
      MV_BEANS: c[POS_B] = ~pos[POS_B];
      default:  ;
    endcase
    return c;
  endfunction

  function automatic logic passenger_away(input logic [3:0] pos, input logic [1:0] sel);
    logic away;
    unique case (sel)
      MV_FOX:   away = pos[POS_X] != pos[POS_F];
      MV_GOAT:  away = pos[POS_G] != pos[POS_F];
      MV_BEANS: away = pos[POS_B] != pos[POS_F];
      default:  away = 1'b0;
    endcase
    return away;
  endfunction

endpackage

// File: rtl/farmer_hazard.sv
// Combinational hazard check: a candidate {f,x,g,b} is unsafe when the goat is
// left without the farmer next to the fox or the beans.
module farmer_hazard
  import farmer_pkg::*;
(
  input  logic [3:0] cand,
  output logic       unsafe
);

  logic goat_alone;

  assign goat_alone = cand[POS_F] != cand[POS_G];
  assign unsafe = goat_alone &&
                  ((cand[POS_X] == cand[POS_G]) || (cand[POS_G] == cand[POS_B]));

endmodule

// File: rtl/farmer_ctrl.sv
// River-crossing sequencer: handshaked move requests, two-cycle check/commit, win/loss.
// Optional undo port and history stack are built when FARMER_UNDO_EN is defined.
module farmer_ctrl
  import farmer_pkg::*;
#(
  parameter int unsigned MAX_MOVES  = 15,
  parameter int unsigned CNT_W      = 4,
  parameter int unsigned HIST_DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             move_valid,
  input  logic [1:0]       move_sel,
`ifdef FARMER_UNDO_EN
  input  logic             undo,
`endif
  output logic             move_ready,
  output logic             accept,
  output logic             reject,
  output logic [1:0]       reject_code,
  output logic [3:0]       pos,
  output logic [CNT_W-1:0] move_cnt,
  output logic             won,
  output logic             lost
);

  state_e           state_q, state_d;
  logic [3:0]       pos_q, pos_d;
  logic [3:0]       cand_q, cand_d;
  logic [1:0]       sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept_q, accept_d;
  logic             reject_q, reject_d;
  logic [1:0]       code_q, code_d;

  logic             unsafe;
  logic             undo_req;
  logic             hist_push, hist_pop, hist_clr;
  logic             hist_empty;
  logic [3:0]       hist_top;

  farmer_hazard u_hazard (
    .cand   (cand_q),
    .unsafe (unsafe)
  );

`ifdef FARMER_UNDO_EN
  localparam int unsigned PtrW  = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1;
  localparam int unsigned HCntW = $clog2(HIST_DEPTH + 1);

  logic [3:0]       hist_q [HIST_DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_inc, top_ptr;
  logic [HCntW-1:0] hist_cnt_q;

  assign undo_req   = undo;
  assign hist_empty = (hist_cnt_q == '0);
  assign wr_ptr_inc = (wr_ptr_q == PtrW'(HIST_DEPTH - 1)) ? '0 : wr_ptr_q + PtrW'(1);
  assign top_ptr    = (wr_ptr_q == '0) ? PtrW'(HIST_DEPTH - 1) : wr_ptr_q - PtrW'(1);
  assign hist_top   = hist_q[top_ptr];

  // Circular stack: when full, a push overwrites the oldest entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      hist_cnt_q <= '0;
    end else if (hist_clr) begin
      wr_ptr_q   <= '0;
      hist_cnt_q <= '0;
    end else if (hist_push) begin
      wr_ptr_q <= wr_ptr_inc;
      if (hist_cnt_q != HCntW'(HIST_DEPTH)) hist_cnt_q <= hist_cnt_q + HCntW'(1);
    end else if (hist_pop) begin
      wr_ptr_q   <= top_ptr;
      hist_cnt_q <= hist_cnt_q - HCntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (hist_push) hist_q[wr_ptr_q] <= pos_q;
  end
`else
  logic unused_hist;

  assign undo_req    = 1'b0;
  assign hist_empty  = 1'b1;
  assign hist_top    = 4'b0000;
  assign unused_hist = hist_push ^ hist_pop ^ hist_clr;
`endif

  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    cand_d    = cand_q;
    sel_d     = sel_q;
    cnt_d     = cnt_q;
    accept_d  = 1'b0;
    reject_d  = 1'b0;
    code_d    = code_q;
    hist_push = 1'b0;
    hist_pop  = 1'b0;
    hist_clr  = 1'b0;

    if (start) begin
      state_d  = StPlay;
      pos_d    = '0;
      cnt_d    = '0;
      hist_clr = 1'b1;
    end else begin
      unique case (state_q)
        StPlay: begin
          if (undo_req) begin
            if (hist_empty) begin
              reject_d = 1'b1;
              code_d   = REJ_UNDO;
            end else begin
              pos_d    = hist_top;
              cnt_d    = cnt_q - CNT_W'(1);
              accept_d = 1'b1;
              code_d   = REJ_NONE;
              hist_pop = 1'b1;
            end
          end else if (move_valid) begin
            state_d = StCheck;
            cand_d  = candidate(pos_q, move_sel);
            sel_d   = move_sel;
          end
        end
        StCheck: begin
          state_d = StPlay;
          if (passenger_away(pos_q, sel_q)) begin
            reject_d = 1'b1;
            code_d   = REJ_BANK;
          end else if (unsafe) begin
            reject_d = 1'b1;
            code_d   = REJ_UNSAFE;
          end else begin
            pos_d     = cand_q;
            cnt_d     = cnt_q + CNT_W'(1);
            accept_d  = 1'b1;
            code_d    = REJ_NONE;
            hist_push = 1'b1;
            // A winning final move is a win, not a loss.
            if (cand_q == 4'b1111)                state_d = StWon;
            else if (cnt_d == CNT_W'(MAX_MOVES)) state_d = StLost;
          end
        end
        StIdle, StWon, StLost: ;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      pos_q    <= '0;
      cand_q   <= '0;
      sel_q    <= MV_ALONE;
      cnt_q    <= '0;
      accept_q <= 1'b0;
      reject_q <= 1'b0;
      code_q   <= REJ_NONE;
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      cand_q   <= cand_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      accept_q <= accept_d;
      reject_q <= reject_d;
      code_q   <= code_d;
    end
  end

  assign move_ready  = (state_q == StPlay) && !undo_req;
  assign accept      = accept_q;
  assign reject      = reject_q;
  assign reject_code = code_q;
  assign pos         = pos_q;
  assign move_cnt    = cnt_q;
  assign won         = (state_q == StWon);
  assign lost        = (state_q == StLost);

endmodule

// File: tb/tb_farmer_ctrl.sv
// Self-checking bench for farmer_ctrl: transaction-level puzzle model checked every cycle,
// plus literal expectations. Undo scenario is exercised when FARMER_UNDO_EN is defined.
module tb_farmer_ctrl;

  localparam int unsigned MaxMoves  = 15;
  localparam int unsigned CntW      = 4;
  localparam int unsigned HistDepth = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic            move_valid;
  logic [1:0]      move_sel;
  logic            move_ready;
  logic            accept;
  logic            reject;
  logic [1:0]      reject_code;
  logic [3:0]      pos;
  logic [CntW-1:0] move_cnt;
  logic            won;
  logic            lost;
`ifdef FARMER_UNDO_EN
  logic            undo;
`endif

  farmer_ctrl #(
    .MAX_MOVES  (MaxMoves),
    .CNT_W      (CntW),
    .HIST_DEPTH (HistDepth)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .move_valid  (move_valid),
    .move_sel    (move_sel),
`ifdef FARMER_UNDO_EN
    .undo        (undo),
`endif
    .move_ready  (move_ready),
    .accept      (accept),
    .reject      (reject),
    .reject_code (reject_code),
    .pos         (pos),
    .move_cnt    (move_cnt),
    .won         (won),
    .lost        (lost)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected outputs, advanced by the stimulus tasks one transaction at a time.
  bit              chk_en = 1'b0;
  logic [3:0]      exp_pos;
  logic [CntW-1:0] exp_cnt;
  logic [1:0]      exp_code;
  logic            exp_accept, exp_reject, exp_won, exp_lost, exp_ready;
  logic [3:0]      hist[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("pos", 32'(pos), 32'(exp_pos));
      check("move_cnt", 32'(move_cnt), 32'(exp_cnt));
      check("reject_code", 32'(reject_code), 32'(exp_code));
      check("accept", 32'(accept), 32'(exp_accept));
      check("reject", 32'(reject), 32'(exp_reject));
      check("won", 32'(won), 32'(exp_won));
      check("lost", 32'(lost), 32'(exp_lost));
      check("move_ready", 32'(move_ready), 32'(exp_ready));
    end
  end

  task automatic model_clear();
    exp_pos    = 4'b0000;
    exp_cnt    = '0;
    exp_accept = 1'b0;
    exp_reject = 1'b0;
    exp_won    = 1'b0;
    exp_lost   = 1'b0;
    hist.delete();
  endtask

  // Puzzle rules: bit 3 farmer, 2 fox, 1 goat, 0 beans; sel 1..3 names bit 3-sel.
  task automatic model_move(input int sel);
    logic [3:0] np;
    int pidx;
    pidx = (sel == 0) ? -1 : 3 - sel;
    np = exp_pos ^ 4'b1000;
    if (pidx >= 0) np[pidx] = ~np[pidx];
    if (pidx >= 0 && exp_pos[pidx] != exp_pos[3]) begin
      exp_reject = 1'b1;
      exp_code   = 2'd1;
    end else if (np[3] != np[1] && (np[2] == np[1] || np[1] == np[0])) begin
      exp_reject = 1'b1;
      exp_code   = 2'd2;
    end else begin
      hist.push_back(exp_pos);
      if (hist.size() > HistDepth) void'(hist.pop_front());
      exp_pos    = np;
      exp_cnt    = exp_cnt + 1'b1;
      exp_accept = 1'b1;
      exp_code   = 2'd0;
      if (np == 4'b1111) exp_won = 1'b1;
      else if (int'(exp_cnt) == MaxMoves) exp_lost = 1'b1;
    end
    exp_ready = !(exp_won || exp_lost);
  endtask

  // All stimulus tasks start and end 1 time unit after a rising edge.
  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    model_clear();
    exp_ready = 1'b1;
  endtask

  task automatic do_move(input int sel);
    logic taken;
    taken      = exp_ready;
    move_valid = 1'b1;
    move_sel   = 2'(sel);
    @(posedge clk); #1;
    move_valid = 1'b0;
    if (!taken) begin
      check("ready_low_no_take", 32'(move_ready), 32'd0);
      return;
    end
    exp_ready = 1'b0;
    @(posedge clk); #1;
    model_move(sel);
    @(posedge clk); #1;
    exp_accept = 1'b0;
    exp_reject = 1'b0;
  endtask

`ifdef FARMER_UNDO_EN
  task automatic do_undo(input bit with_move);
    undo       = 1'b1;
    move_valid = with_move;
    move_sel   = 2'b10;
    exp_ready  = 1'b0;
    @(posedge clk); #1;
    undo       = 1'b0;
    move_valid = 1'b0;
    if (hist.size() == 0) begin
      exp_reject = 1'b1;
      exp_code   = 2'd3;
    end else begin
      exp_pos    = hist.pop_back();
      exp_cnt    = exp_cnt - 1'b1;
      exp_accept = 1'b1;
      exp_code   = 2'd0;
    end
    exp_ready = 1'b1;
    @(posedge clk); #1;
    exp_accept = 1'b0;
    exp_reject = 1'b0;
  endtask
`endif

  int seq1[7] = '{2, 0, 1, 2, 3, 0, 2};
  int shuttle[4] = '{2, 0, 0, 2};

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    move_valid = 1'b0;
    move_sel   = 2'b00;
`ifdef FARMER_UNDO_EN
    undo       = 1'b0;
`endif
    model_clear();
    exp_code  = 2'd0;
    exp_ready = 1'b0;
    chk_en    = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    check("idle_ready", 32'(move_ready), 32'd0);

    // 1: solve the puzzle in seven moves
    do_start();
    foreach (seq1[i]) do_move(seq1[i]);
    check("t1_pos", 32'(pos), 32'hf);
    check("t1_cnt", 32'(move_cnt), 32'd7);
    check("t1_won", 32'(won), 32'd1);
    do_move(1);

    // 2: unsafe moves from the start bank
    do_start();
    do_move(1);
    check("t2_fox_code", 32'(reject_code), 32'd2);
    check("t2_fox_pos", 32'(pos), 32'h0);
    do_move(0);
    check("t2_alone_code", 32'(reject_code), 32'd2);
    check("t2_cnt", 32'(move_cnt), 32'd0);

    // 3: passenger on the wrong bank
    do_start();
    do_move(2);
    do_move(0);
    check("t3_mid_pos", 32'(pos), 32'h2);
    check("t3_code_cleared", 32'(reject_code), 32'd0);
    do_move(2);
    check("t3_code", 32'(reject_code), 32'd1);
    check("t3_pos", 32'(pos), 32'h2);

    // 4: exhaust the move budget without winning
    do_start();
    for (int i = 0; i < 15; i++) do_move(shuttle[i % 4]);
    check("t4_lost", 32'(lost), 32'd1);
    check("t4_cnt", 32'(move_cnt), 32'd15);
    do_start();
    check("t4_restart_cnt", 32'(move_cnt), 32'd0);
    check("t4_restart_ready", 32'(move_ready), 32'd1);

    // 5: reset while a move is in CHECK
    do_move(2);
    move_valid = 1'b1;
    move_sel   = 2'b10;
    @(posedge clk); #1;
    move_valid = 1'b0;
    exp_ready  = 1'b0;
    #1 reset = 1'b1;
    model_clear();
    exp_code = 2'd0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    check("t5_pos", 32'(pos), 32'h0);
    check("t5_idle_ready", 32'(move_ready), 32'd0);

`ifdef FARMER_UNDO_EN
    // 6: undo, undo on empty history, undo beats a simultaneous move
    do_start();
    do_move(2);
    do_undo(1'b0);
    check("t6_pos", 32'(pos), 32'h0);
    check("t6_cnt", 32'(move_cnt), 32'd0);
    do_undo(1'b0);
    check("t6_empty_code", 32'(reject_code), 32'd3);
    do_undo(1'b1);
    check("t6_move_not_taken", 32'(pos), 32'h0);
`endif

    @(posedge clk); #1;
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
